// File: rtl/iob_eth_regs_responder_if.sv
// iob_eth_regs_responder_if: IOb native bus between an initiator (master) and a responder (slave).
interface iob_eth_regs_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  modport master (output valid, address, wdata, wstrb, input rdata, ready);
  modport slave (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_eth_regs_responder.sv
// iob_eth_regs_responder: Ethernet MAC register block (MODER/INT_SOURCE/INT_MASK) on the IOb native bus.
// Define ETH_RESP_BD_RAM_EN to instantiate the buffer-descriptor RAM at 0x400..0x7FF.
module iob_eth_regs_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int BD_WORDS    = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  iob_eth_regs_responder_if.slave       bus,
  input  logic [6:0]                    int_event_i,
  output logic                          interrupt_o,
  output logic [31:0]                   moder_o
);
  if (DATA_W != 32) begin : g_bad_data_w
    $error("DATA_W must be 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be 0..15");
  end
  if (BD_WORDS < 2 || BD_WORDS > 256) begin : g_bad_bd
    $error("BD_WORDS must fit the 0x400..0x7FF window");
  end
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_moder, r_rdata;
  logic [3:0]        r_wstrb;
  logic [6:0]        r_int_src, r_int_mask;
  logic              r_irq;
  logic              w_accept, w_enter, w_wr, w_hit_moder, w_hit_src, w_hit_mask, w_hit_bd;
  logic [31:0]       w_bmask, w_moder_nxt, w_bd_rd, w_rd;
  logic [6:0]        w_clr, w_src_nxt, w_mask_nxt;
  // A request leaving RESP may be accepted on the same edge, so there is no dead cycle.
  assign w_accept    = bus.valid && (r_state == S_IDLE || r_state == S_RESP);
  assign w_enter     = r_state == S_WAIT && r_cnt == 4'd0;
  assign w_wr        = w_enter && |r_wstrb;
  assign w_hit_moder = r_addr[ADDR_W-1:2] == (ADDR_W-2)'(0);
  assign w_hit_src   = r_addr[ADDR_W-1:2] == (ADDR_W-2)'(1);
  assign w_hit_mask  = r_addr[ADDR_W-1:2] == (ADDR_W-2)'(2);
  assign w_hit_bd    = r_addr[ADDR_W-1:10] == (ADDR_W-10)'(1);
  assign w_bmask     = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_moder_nxt = (w_wr && w_hit_moder) ? (r_moder & ~w_bmask) | (r_wdata & w_bmask) : r_moder;
  assign w_clr       = (w_wr && w_hit_src && r_wstrb[0]) ? r_wdata[6:0] : 7'd0;
  assign w_src_nxt   = (r_int_src & ~w_clr) | int_event_i;
  assign w_mask_nxt  = (w_wr && w_hit_mask && r_wstrb[0]) ? r_wdata[6:0] : r_int_mask;
  // Reads see the register state after this edge's events have been applied.
  assign w_rd = w_hit_moder ? w_moder_nxt :
                w_hit_src   ? {25'd0, w_src_nxt} :
                w_hit_mask  ? {25'd0, w_mask_nxt} :
                w_hit_bd    ? w_bd_rd : 32'd0;
`ifdef ETH_RESP_BD_RAM_EN
  localparam int BD_AW = $clog2(BD_WORDS);
  logic [31:0]      r_bd [BD_WORDS];
  logic [BD_AW-1:0] w_bd_idx;
  assign w_bd_idx = r_addr[2 +: BD_AW];
  assign w_bd_rd  = r_bd[w_bd_idx];
  always_ff @(posedge clk_i)
    if (rst_n_i && w_wr && w_hit_bd) r_bd[w_bd_idx] <= (r_bd[w_bd_idx] & ~w_bmask) | (r_wdata & w_bmask);
`else
  assign w_bd_rd = 32'd0;
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_moder    <= 32'h0000_A000;
      r_int_src  <= 7'd0;
      r_int_mask <= 7'd0;
      r_rdata    <= 32'd0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_accept ? S_WAIT : w_enter ? S_RESP : r_state == S_RESP ? S_IDLE : r_state;
      r_cnt      <= w_accept ? 4'(WAIT_STATES) : (r_state == S_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      if (w_accept) begin
        r_addr  <= bus.address;
        r_wdata <= bus.wdata;
        r_wstrb <= bus.wstrb;
      end
      r_moder    <= w_moder_nxt;
      r_int_src  <= w_src_nxt;
      r_int_mask <= w_mask_nxt;
      r_rdata    <= (w_enter && !w_wr) ? w_rd : 32'd0;
      r_irq      <= |(r_int_src & r_int_mask);
    end
  end
  assign bus.ready   = r_state == S_RESP;
  assign bus.rdata   = r_rdata;
  assign interrupt_o = r_irq;
  assign moder_o     = r_moder;
endmodule
